heap_pq_engine: RTL and testbench

//   Parametrised binary-heap priority queue with start/done command handshake.

---
 rtl/heap_pq_engine.sv | 217 +++++++++++++++++++++
 tb/tb_heap_pq_engine.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/heap_pq_engine.sv
// Binary-heap priority queue (max or min) with start/done command handshake.
// Ports: clk, reset (async, active-low), start, instruction, key in;
//   busy, done, err, arr_out (root), pop_key, n (occupancy) out.
// Optional: define HEAP_REPLACE_EN to enable instruction 11 (replace-top).
module heap_pq_engine #(
  parameter int DATA_W   = 32,
  parameter int DEPTH    = 1024,
  parameter int CNT_W    = $clog2(DEPTH + 1),
  parameter int MAX_HEAP = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [1:0]        instruction,
  input  logic [DATA_W-1:0] key,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [DATA_W-1:0] arr_out,
  output logic [DATA_W-1:0] pop_key,
  output logic [CNT_W-1:0]  n
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int LW    = CNT_W + 1;

  typedef enum logic [1:0] {
    IDLE,
    SIFT_UP,
    SIFT_DN,
    FIN
  } state_t;

  function automatic logic better(
    input logic [DATA_W-1:0] a,
    input logic [DATA_W-1:0] b
  );
    if (MAX_HEAP != 0) return a > b;
    else return a < b;
  endfunction

  logic [DATA_W-1:0] arr_q [DEPTH];

  state_t            state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [CNT_W-1:0]  n_q, n_d;
  logic [DATA_W-1:0] pop_key_q, pop_key_d;
  logic              errp_q, errp_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              err_q, err_d;

  logic              we0, we1;
  logic [IDX_W-1:0]  wa0, wa1;
  logic [DATA_W-1:0] wd0, wd1;

  logic [IDX_W-1:0]  par_idx, c_idx, n_lo, nm1_lo;
  logic [LW-1:0]     l_w, r_w;
  logic              has_l, has_r;
  logic [DATA_W-1:0] cur_key, par_key;
  logic [DATA_W-1:0] l_key, r_key, c_key;

  // Neighbourhood of the current sift index.
  always_comb begin
    n_lo    = n_q[IDX_W-1:0];
    nm1_lo  = n_lo - IDX_W'(1);
    cur_key = arr_q[idx_q];
    par_idx = (idx_q - IDX_W'(1)) >> 1;
    par_key = arr_q[par_idx];
    l_w     = LW'({idx_q, 1'b1});
    r_w     = l_w + LW'(1);
    has_l   = l_w < {1'b0, n_q};
    has_r   = r_w < {1'b0, n_q};
    l_key   = arr_q[l_w[IDX_W-1:0]];
    r_key   = arr_q[r_w[IDX_W-1:0]];
    // Left child wins ties.
    if (has_r && better(r_key, l_key)) begin
      c_idx = r_w[IDX_W-1:0];
      c_key = r_key;
    end else begin
      c_idx = l_w[IDX_W-1:0];
      c_key = l_key;
    end
  end

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    n_d       = n_q;
    pop_key_d = pop_key_q;
    errp_d    = errp_q;
    we0       = 1'b0;
    we1       = 1'b0;
    wa0       = '0;
    wa1       = '0;
    wd0       = '0;
    wd1       = '0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          // Nop and rejected commands leave via the idx==0
          // sift-up exit, giving every command a 2-cycle floor.
          state_d = SIFT_UP;
          idx_d   = '0;
          errp_d  = 1'b0;
          unique case (instruction)
            2'b00: ;
            2'b01: begin
              if (n_q == CNT_W'(DEPTH)) begin
                errp_d = 1'b1;
              end else begin
                we0   = 1'b1;
                wa0   = n_lo;
                wd0   = key;
                n_d   = n_q + CNT_W'(1);
                idx_d = n_lo;
              end
            end
            2'b10: begin
              if (n_q == '0) begin
                errp_d = 1'b1;
              end else begin
                pop_key_d = arr_q[0];
                we0       = 1'b1;
                wa0       = '0;
                wd0       = arr_q[nm1_lo];
                n_d       = n_q - CNT_W'(1);
                state_d   = SIFT_DN;
              end
            end
            2'b11: begin
`ifdef HEAP_REPLACE_EN
              if (n_q == '0) begin
                errp_d = 1'b1;
              end else begin
                pop_key_d = arr_q[0];
                we0       = 1'b1;
                wa0       = '0;
                wd0       = key;
                state_d   = SIFT_DN;
              end
`else
              errp_d = 1'b1;
`endif
            end
          endcase
        end
      end
      SIFT_UP: begin
        if (idx_q != '0 && better(cur_key, par_key)) begin
          we0   = 1'b1;
          wa0   = idx_q;
          wd0   = par_key;
          we1   = 1'b1;
          wa1   = par_idx;
          wd1   = cur_key;
          idx_d = par_idx;
        end else begin
          state_d = FIN;
        end
      end
      SIFT_DN: begin
        if (has_l && better(c_key, cur_key)) begin
          we0   = 1'b1;
          wa0   = idx_q;
          wd0   = c_key;
          we1   = 1'b1;
          wa1   = c_idx;
          wd1   = cur_key;
          idx_d = c_idx;
        end else begin
          state_d = FIN;
        end
      end
      FIN: state_d = IDLE;
    endcase
    busy_d = (state_d == SIFT_UP) || (state_d == SIFT_DN);
    done_d = (state_d == FIN);
    err_d  = (state_d == FIN) && errp_q;
  end

  // Storage is not reset; entries at index >= n are don't-care.
  always_ff @(posedge clk) begin
    if (we0) arr_q[wa0] <= wd0;
    if (we1) arr_q[wa1] <= wd1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      n_q       <= '0;
      pop_key_q <= '0;
      errp_q    <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      n_q       <= n_d;
      pop_key_q <= pop_key_d;
      errp_q    <= errp_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign err     = err_q;
  assign n       = n_q;
  assign pop_key = pop_key_q;
  assign arr_out = (n_q == '0) ? '0 : arr_q[0];

endmodule

// File: tb/tb_heap_pq_engine.sv
// Bench for heap_pq_engine: a max-heap and a min-heap instance (DEPTH=8)
// driven from a vector table through a scoreboard queue, plus reset abort.
module tb_heap_pq_engine;

  localparam int DW  = 32;
  localparam int DEP = 8;
  localparam int CW  = $clog2(DEP + 1);

  typedef struct {
    int          sel;
    logic [1:0]  ins;
    logic [31:0] key;
    logic        e_err;
    logic [31:0] e_top;
    int          e_n;
    logic        c_pop;
    logic [31:0] e_pop;
  } vec_t;

  logic          clk = 1'b0;
  logic          reset;
  logic          st     [2];
  logic [1:0]    ins;
  logic [DW-1:0] kin;
  logic          busy_o [2];
  logic          done_o [2];
  logic          err_o  [2];
  logic [DW-1:0] top_o  [2];
  logic [DW-1:0] pk_o   [2];
  logic [CW-1:0] n_o    [2];

  int   n_cmp = 0;
  int   n_bad = 0;
  int   vid   = 0;
  vec_t tbl   [$];
  vec_t exp_q [$];

  always #5 clk = ~clk;

  heap_pq_engine #(.DATA_W(DW), .DEPTH(DEP), .MAX_HEAP(1)) u_max (
    .clk(clk), .reset(reset), .start(st[0]),
    .instruction(ins), .key(kin),
    .busy(busy_o[0]), .done(done_o[0]), .err(err_o[0]),
    .arr_out(top_o[0]), .pop_key(pk_o[0]), .n(n_o[0])
  );

  heap_pq_engine #(.DATA_W(DW), .DEPTH(DEP), .MAX_HEAP(0)) u_min (
    .clk(clk), .reset(reset), .start(st[1]),
    .instruction(ins), .key(kin),
    .busy(busy_o[1]), .done(done_o[1]), .err(err_o[1]),
    .arr_out(top_o[1]), .pop_key(pk_o[1]), .n(n_o[1])
  );

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(input int sel, input logic [1:0] i,
                              input int k, input logic e,
                              input int top, input int nn,
                              input logic cp, input int pk);
    vec_t v;
    v.sel = sel; v.ins = i; v.key = k; v.e_err = e;
    v.e_top = top; v.e_n = nn; v.c_pop = cp; v.e_pop = pk;
    return v;
  endfunction

  task automatic run_vec(input vec_t v);
    vec_t  e;
    int    cyc;
    int    s;
    string t;
    s = v.sel;
    vid++;
    t = $sformatf("v%0d_", vid);
    @(negedge clk);
    ins = v.ins;
    kin = v.key;
    st[s] = 1'b1;
    exp_q.push_back(v);
    @(negedge clk);
    st[s] = 1'b0;
    cyc = 1;
    chk({t, "busy"}, 32'(busy_o[s]), 1);
    while (!done_o[s] && cyc < 30) begin
      @(negedge clk);
      cyc++;
    end
    e = exp_q.pop_front();
    if (!done_o[s]) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %stimeout: got no done expected done", t);
    end else if (e.e_err) begin
      chk({t, "lat"}, cyc, 2);
    end else begin
      n_cmp++;
      if (cyc < 2 || cyc > 5) begin
        n_bad++;
        $display("FAIL %slat: got %0d expected 2..5", t, cyc);
      end
    end
    chk({t, "err"}, 32'(err_o[s]), 32'(e.e_err));
    chk({t, "top"}, top_o[s], e.e_top);
    chk({t, "n"}, 32'(n_o[s]), e.e_n);
    if (e.c_pop) chk({t, "pop"}, pk_o[s], e.e_pop);
  endtask

  task automatic chk_reset_state();
    for (int s = 0; s < 2; s++) begin
      chk($sformatf("rst%0d_n", s), 32'(n_o[s]), 0);
      chk($sformatf("rst%0d_top", s), top_o[s], 0);
      chk($sformatf("rst%0d_busy", s), 32'(busy_o[s]), 0);
      chk($sformatf("rst%0d_done", s), 32'(done_o[s]), 0);
      chk($sformatf("rst%0d_err", s), 32'(err_o[s]), 0);
      chk($sformatf("rst%0d_pk", s), pk_o[s], 0);
    end
  endtask

  initial begin
    logic seen;
    reset = 1'b0;
    st[0] = 1'b0;
    st[1] = 1'b0;
    ins   = 2'b00;
    kin   = '0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk_reset_state();

    // Max heap: basic push/pop and underflow.
    tbl.push_back(mk(0, 2'b01, 5,  0, 5,  1, 0, 0));
    tbl.push_back(mk(0, 2'b01, 9,  0, 9,  2, 0, 0));
    tbl.push_back(mk(0, 2'b01, 3,  0, 9,  3, 0, 0));
    tbl.push_back(mk(0, 2'b01, 12, 0, 12, 4, 0, 0));
    tbl.push_back(mk(0, 2'b10, 0,  0, 9,  3, 1, 12));
    tbl.push_back(mk(0, 2'b10, 0,  0, 5,  2, 1, 9));
    tbl.push_back(mk(0, 2'b10, 0,  0, 3,  1, 1, 5));
    tbl.push_back(mk(0, 2'b10, 0,  0, 0,  0, 1, 3));
    tbl.push_back(mk(0, 2'b10, 0,  1, 0,  0, 1, 3));
    // Fill to DEPTH, overflow, then drain in order.
    tbl.push_back(mk(0, 2'b01, 4,  0, 4,  1, 0, 0));
    tbl.push_back(mk(0, 2'b01, 15, 0, 15, 2, 0, 0));
    tbl.push_back(mk(0, 2'b01, 7,  0, 15, 3, 0, 0));
    tbl.push_back(mk(0, 2'b01, 22, 0, 22, 4, 0, 0));
    tbl.push_back(mk(0, 2'b01, 1,  0, 22, 5, 0, 0));
    tbl.push_back(mk(0, 2'b01, 30, 0, 30, 6, 0, 0));
    tbl.push_back(mk(0, 2'b01, 9,  0, 30, 7, 0, 0));
    tbl.push_back(mk(0, 2'b01, 11, 0, 30, 8, 0, 0));
    tbl.push_back(mk(0, 2'b01, 100, 1, 30, 8, 1, 3));
    tbl.push_back(mk(0, 2'b10, 0, 0, 22, 7, 1, 30));
    tbl.push_back(mk(0, 2'b10, 0, 0, 15, 6, 1, 22));
    tbl.push_back(mk(0, 2'b10, 0, 0, 11, 5, 1, 15));
    tbl.push_back(mk(0, 2'b10, 0, 0, 9,  4, 1, 11));
    tbl.push_back(mk(0, 2'b10, 0, 0, 7,  3, 1, 9));
    tbl.push_back(mk(0, 2'b10, 0, 0, 4,  2, 1, 7));
    tbl.push_back(mk(0, 2'b10, 0, 0, 1,  1, 1, 4));
    tbl.push_back(mk(0, 2'b10, 0, 0, 0,  0, 1, 1));
    // Replace-top on {12,9,5}.
    tbl.push_back(mk(0, 2'b01, 12, 0, 12, 1, 0, 0));
    tbl.push_back(mk(0, 2'b01, 9,  0, 12, 2, 0, 0));
    tbl.push_back(mk(0, 2'b01, 5,  0, 12, 3, 0, 0));
`ifdef HEAP_REPLACE_EN
    tbl.push_back(mk(0, 2'b11, 1, 0, 9, 3, 1, 12));
    tbl.push_back(mk(0, 2'b10, 0, 0, 5, 2, 1, 9));
    tbl.push_back(mk(0, 2'b10, 0, 0, 1, 1, 1, 5));
    tbl.push_back(mk(0, 2'b10, 0, 0, 0, 0, 1, 1));
`else
    tbl.push_back(mk(0, 2'b11, 1, 1, 12, 3, 1, 1));
    tbl.push_back(mk(0, 2'b10, 0, 0, 9, 2, 1, 12));
    tbl.push_back(mk(0, 2'b10, 0, 0, 5, 1, 1, 9));
    tbl.push_back(mk(0, 2'b10, 0, 0, 0, 0, 1, 5));
`endif
    tbl.push_back(mk(0, 2'b00, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 2'b11, 7, 1, 0, 0, 0, 0));
    // Min heap with duplicate keys.
    tbl.push_back(mk(1, 2'b01, 7, 0, 7, 1, 0, 0));
    tbl.push_back(mk(1, 2'b01, 2, 0, 2, 2, 0, 0));
    tbl.push_back(mk(1, 2'b01, 9, 0, 2, 3, 0, 0));
    tbl.push_back(mk(1, 2'b01, 2, 0, 2, 4, 0, 0));
    tbl.push_back(mk(1, 2'b10, 0, 0, 2, 3, 1, 2));
    tbl.push_back(mk(1, 2'b10, 0, 0, 7, 2, 1, 2));
    tbl.push_back(mk(1, 2'b10, 0, 0, 9, 1, 1, 7));
    tbl.push_back(mk(1, 2'b00, 0, 0, 9, 1, 1, 7));
    tbl.push_back(mk(1, 2'b10, 0, 0, 0, 0, 1, 9));
    tbl.push_back(mk(1, 2'b10, 0, 1, 0, 0, 1, 9));

    foreach (tbl[i]) run_vec(tbl[i]);

    // Reset abort while a push is sifting.
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    run_vec(mk(0, 2'b01, 10, 0, 10, 1, 0, 0));
    run_vec(mk(0, 2'b01, 20, 0, 20, 2, 0, 0));
    run_vec(mk(0, 2'b01, 30, 0, 30, 3, 0, 0));
    run_vec(mk(0, 2'b01, 40, 0, 40, 4, 0, 0));
    @(negedge clk);
    ins   = 2'b01;
    kin   = 50;
    st[0] = 1'b1;
    @(negedge clk);
    st[0] = 1'b0;
    chk("abort_busy", 32'(busy_o[0]), 1);
    reset = 1'b0;
    seen  = 1'b0;
    #1;
    chk("abort_n", 32'(n_o[0]), 0);
    chk("abort_busy0", 32'(busy_o[0]), 0);
    chk("abort_top", top_o[0], 0);
    repeat (2) begin
      @(negedge clk);
      if (done_o[0]) seen = 1'b1;
    end
    reset = 1'b1;
    repeat (6) begin
      @(negedge clk);
      if (done_o[0]) seen = 1'b1;
    end
    chk("abort_nodone", 32'(seen), 0);
    chk("abort_pk", pk_o[0], 0);
    run_vec(mk(0, 2'b01, 4, 0, 4, 1, 0, 0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
